// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a zero register, write-first
// read bypass, a register mirrored to a display port and a sequenced bulk clear.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int PORTW    = 16,
  parameter int PORT_REG = (2**AW) - 1
) (
  input  logic            clkIn,
  input  logic            resetIn,
  input  logic [AW-1:0]   rs1In,
  input  logic [AW-1:0]   rs2In,
  input  logic [AW-1:0]   rdIn,
  input  logic [XLEN-1:0] DataIn,
  input  logic            WriteIn,
  input  logic            clrIn,
  output logic [XLEN-1:0] Data1Out,
  output logic [XLEN-1:0] Data2Out,
  output logic [PORTW-1:0] portOut,
  output logic            busyOut,
  output logic            doneOut
);

  localparam int unsigned NREG     = 2**AW;
  localparam logic [AW-1:0] LAST   = '1;
  localparam logic [AW-1:0] PORT_IDX = AW'(PORT_REG);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_ok;

  // A write is accepted only when idle, out of reset, and not aimed at x0.
  assign wr_ok = (state_q == IDLE) && WriteIn && (rdIn != '0) && !resetIn;

  // Next-state, clear counter and register-array update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    if (wr_ok) begin
      regs_d[rdIn] = DataIn;
    end
    unique case (state_q)
      IDLE: begin
        if (clrIn) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        // Stop at the last register instead of letting the counter wrap.
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registers; reset clears everything immediately.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational reads with x0 forced to zero and write-first bypass.
  always_comb begin
    Data1Out = '0;
    Data2Out = '0;
    if (rs1In != '0) begin
      Data1Out = (wr_ok && (rdIn == rs1In)) ? DataIn : regs_q[rs1In];
    end
    if (rs2In != '0) begin
      Data2Out = (wr_ok && (rdIn == rs2In)) ? DataIn : regs_q[rs2In];
    end
  end

  assign portOut = regs_q[PORT_IDX][PORTW-1:0];
  assign busyOut = (state_q != IDLE);
  assign doneOut = (state_q == DONE);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for reads/writes/bypass,
// hand-written sequences for bulk clear and reset abort.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] din;
  logic        we, clr;
  logic [31:0] d1, d2;
  logic [15:0] port;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.XLEN(32), .AW(5), .PORTW(16), .PORT_REG(31)) dut (
    .clkIn(clk), .resetIn(rst), .rs1In(rs1), .rs2In(rs2), .rdIn(rd),
    .DataIn(din), .WriteIn(we), .clrIn(clr), .Data1Out(d1), .Data2Out(d2),
    .portOut(port), .busyOut(busy), .doneOut(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ep;
  } vec_t;

  vec_t vt [10];

  initial begin
    int busy_cnt, done_at, done_num, cyc, b, bad_busy, bad_done;

    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        16'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 16'h0};
    vt[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 16'h0};
    vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        16'h0};
    vt[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0};
    vt[5] = '{1'b1, 5'd31, 32'h0001ABCD, 5'd31, 5'd7,  32'h0001ABCD, 32'hA5A5A5A5, 16'h0};
    vt[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h0001ABCD, 32'hDEADBEEF, 16'hABCD};
    vt[7] = '{1'b1, 5'd31, 32'hFFFF0000, 5'd30, 5'd31, 32'h0,        32'hFFFF0000, 16'hABCD};
    vt[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hFFFF0000, 32'hA5A5A5A5, 16'h0000};
    vt[9] = '{1'b1, 5'd3,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 16'h0000};

    rst = 1'b0; we = 1'b0; clr = 1'b0; rd = '0; din = '0; rs1 = 5'd5; rs2 = 5'd31;
    #2 rst = 1'b1;
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_port", {16'b0, port}, 32'h0);
    check("reset_d1",   d1, 32'h0);
    check("reset_d2",   d2, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven reads, writes and bypass while idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we = vt[i].we; rd = vt[i].rd; din = vt[i].din; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      #1;
      check($sformatf("vec%0d_d1", i), d1, vt[i].e1);
      check($sformatf("vec%0d_d2", i), d2, vt[i].e2);
      check($sformatf("vec%0d_port", i), {16'b0, port}, {16'b0, vt[i].ep});
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h0);
    end

    // Fill x1..x30, then write x31 in the same cycle as the clear request.
    for (int i = 1; i < 31; i++) begin
      @(negedge clk);
      we = 1'b1; rd = 5'(i); din = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    we = 1'b1; rd = 5'd31; din = 32'h1000_001F; clr = 1'b1;

    busy_cnt = 0; done_at = 0; done_num = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      we = 1'b0; clr = 1'b0;
      if (busy) busy_cnt++;
      else if (busy_cnt > 0) break;
      if (done) begin
        done_at = busy_cnt;
        done_num++;
      end
      if (busy_cnt == 1) begin
        rs1 = 5'd31;
        #1 check("clr_write_same_cycle", d1, 32'h1000_001F);
      end
      if (busy_cnt == 5) clr = 1'b1;
      if (busy_cnt == 10) begin
        we = 1'b1; rd = 5'd31; din = 32'hCAFEF00D; rs1 = 5'd31; rs2 = 5'd2;
        #1;
        check("busy_no_bypass_d1", d1, 32'h1000_001F);
        check("busy_cleared_d2",   d2, 32'h0);
      end
      if (busy_cnt == 32) begin
        we = 1'b1; rd = 5'd9; din = 32'hFFFFFFFF;
      end
    end
    we = 1'b0;
    check("clear_timeout", (cyc < 100) ? 32'd1 : 32'd0, 32'd1);
    check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clear_done_cycle",  32'(done_at), 32'd32);
    check("clear_done_pulses", 32'(done_num), 32'd1);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check($sformatf("cleared_x%0d", i), d1, 32'h0);
      check($sformatf("cleared_x%0d_p2", 31 - i), d2, 32'h0);
    end
    check("cleared_port", {16'b0, port}, 32'h0);

    // Reset asserted between edges in the middle of a clear.
    @(negedge clk); we = 1'b1; rd = 5'd4;  din = 32'h0000_0044;
    @(negedge clk); we = 1'b1; rd = 5'd31; din = 32'h0000_1F1F;
    @(negedge clk); we = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    b = 0;
    if (busy) b = 1;
    for (int k = 0; k < 50 && b < 10; k++) begin
      @(negedge clk);
      if (busy) b++;
    end
    check("abort_reached_cycle10", 32'(b), 32'd10);
    rs1 = 5'd31;
    #1 check("abort_port_before", {16'b0, port}, 32'h1F1F);
    #1 rst = 1'b1;
    #1;
    check("abort_busy_now", {31'b0, busy}, 32'h0);
    check("abort_done_now", {31'b0, done}, 32'h0);
    check("abort_port_now", {16'b0, port}, 32'h0);
    check("abort_x31_now",  d1, 32'h0);
    we = 1'b1; rd = 5'd4; din = 32'h0000_0077; clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; clr = 1'b0;
    bad_busy = 0; bad_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bad_busy++;
      if (done) bad_done++;
    end
    check("abort_no_busy_after", 32'(bad_busy), 32'd0);
    check("abort_no_done_after", 32'(bad_done), 32'd0);
    rs1 = 5'd4; rs2 = 5'd31;
    #1;
    check("abort_x4_zero",  d1, 32'h0);
    check("abort_x31_zero", d2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of every register and data port.
REQ-002 The block SHALL have parameter AW, default 5, meaning the register address width; register count NREG = 2**AW.
REQ-003 The block SHALL have parameter PORTW, default 16, meaning the width of portOut (PORTW <= XLEN).
REQ-004 The block SHALL have parameter PORT_REG, default NREG-1, meaning the index of the register mirrored on portOut.
REQ-005 The block SHALL have port clkIn, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port resetIn, input, 1, the reset; asynchronous, active-high.
REQ-007 The block SHALL have ports rs1In and rs2In, inputs, AW each, the read addresses for ports 1 and 2.
REQ-008 The block SHALL have port rdIn, input, AW, the write address.
REQ-009 The block SHALL have port DataIn, input, XLEN, the write data.
REQ-010 The block SHALL have port WriteIn, input, 1, the write enable.
REQ-011 The block SHALL have port clrIn, input, 1, a bulk-clear request.
REQ-012 The block SHALL have ports Data1Out and Data2Out, outputs, XLEN each, the read data for ports 1 and 2.
REQ-013 The block SHALL have port portOut, output, PORTW, carrying Reg[PORT_REG][PORTW-1:0] for display.
REQ-014 The block SHALL have port busyOut, output, 1, high while a bulk clear is in progress.
REQ-015 The block SHALL have port doneOut, output, 1, a one-cycle pulse marking bulk-clear completion.

Function
REQ-016 Reads SHALL be combinational; DataNOut = Reg[rsNIn], except as modified by REQ-017 and REQ-018.
REQ-017 Register 0 SHALL read as 0 at all times; writes to address 0 SHALL be discarded.
REQ-018 Write-first bypass SHALL apply: in IDLE, if WriteIn=1, rdIn!=0 and rdIn==rsNIn, then DataNOut=DataIn in that same cycle.
REQ-019 In IDLE, WriteIn=1 SHALL load Reg[rdIn] with DataIn at the rising edge.
REQ-020 portOut SHALL reflect the stored register value, with no bypass applied, and update the cycle after the write.
REQ-021 The FSM SHALL have three states: IDLE, CLEAR, DONE.
REQ-022 In IDLE, clrIn=1 SHALL transition to CLEAR and load the clear counter with 1.
REQ-023 In CLEAR, each cycle SHALL zero Reg[counter] and increment the counter; when the counter reaches NREG-1, the next state SHALL be DONE; CLEAR therefore lasts NREG-1 cycles.
REQ-024 DONE SHALL last one cycle with doneOut=1, then return to IDLE.
REQ-025 busyOut SHALL be 1 in CLEAR and DONE, and 0 in IDLE.
REQ-026 While busyOut=1, WriteIn SHALL be ignored and the bypass SHALL be disabled; reads SHALL return stored contents (cleared or not yet cleared).
REQ-027 clrIn asserted while busyOut=1 SHALL be ignored, with no restart and no queuing.
REQ-028 If clrIn=1 and WriteIn=1 occur in the same IDLE cycle, the write SHALL complete, and that register SHALL then be cleared by the sequence.
REQ-029 The clear counter SHALL be AW bits wide, and its terminal compare SHALL not wrap past NREG-1.

Reset
REQ-030 Assertion of resetIn SHALL immediately, without waiting for a clock edge, zero all NREG registers, force state IDLE, zero the counter, and drive busyOut=0 and doneOut=0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence; after deassertion the block SHALL be in IDLE with all registers 0, and no doneOut pulse shall occur.
REQ-032 While resetIn=1, WriteIn and clrIn SHALL have no effect.

Verification
REQ-033 Reset, write 0xDEADBEEF to x5, then set rs1In=5 -> Data1Out=0xDEADBEEF; write 0x1234 to x0 -> reading x0 returns 0.
REQ-034 WriteIn=1, rdIn=7, DataIn=0xA5A5A5A5 with rs1In=rs2In=7 in the same cycle -> both outputs =0xA5A5A5A5 in that cycle (bypass).
REQ-035 Write 0x0001ABCD to x31 -> portOut=0xABCD on the following cycle; portOut stays at its old value during the write cycle.
REQ-036 Fill x1..x31 with nonzero values, then pulse clrIn -> busyOut=1 for 32 cycles, doneOut high in the 32nd, and all reads =0 afterwards; a WriteIn applied mid-clear has no effect.
REQ-037 Assert resetIn asynchronously, between clock edges, at clear cycle 10 -> busyOut falls at once, with no doneOut pulse and all registers =0.
REQ-038 clrIn pulsed again at clear cycle 5 -> total busy duration remains 32 cycles.
